// File: rtl/conv_pkg.sv
// Shared helpers for the convolution datapath: width derivation and tap slicing.
package conv_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int sum_w(input int data_w, input int ksize);
    return 2 * data_w + clog2(ksize * ksize);
  endfunction

  // Channel counter is at least one bit wide even when a single channel is used.
  function automatic int ch_w(input int in_ch);
    return (in_ch < 2) ? 1 : clog2(in_ch);
  endfunction

  // Tap 0 (top-left) sits in the MSBs of a packed window.
  function automatic int tap_lsb(input int idx, input int ntaps, input int data_w);
    return (ntaps - 1 - idx) * data_w;
  endfunction

endpackage

// File: rtl/conv_dot_kxk.sv
// KxK dot product: registered multiplier array (S1) and registered adder tree (S2),
// with an opaque tag carried alongside each valid beat.
module conv_dot_kxk
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KSIZE  = 3,
  parameter int TAG_W  = 1,
  localparam int NTAPS  = KSIZE * KSIZE,
  localparam int PROD_W = prod_w(DATA_W),
  localparam int SUM_W  = sum_w(DATA_W, KSIZE)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [TAG_W-1:0]           tag_i,
  input  logic [NTAPS*DATA_W-1:0]    fm_i,
  input  logic [NTAPS*DATA_W-1:0]    wt_i,
  output logic                       valid_o,
  output logic [TAG_W-1:0]           tag_o,
  output logic signed [SUM_W-1:0]    sum_o
);

  logic signed [DATA_W-1:0] fm_tap  [NTAPS];
  logic signed [DATA_W-1:0] wt_tap  [NTAPS];
  logic signed [PROD_W-1:0] prod_c  [NTAPS];
  logic signed [PROD_W-1:0] prod_q  [NTAPS];
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SUM_W-1:0]  sum_q;
  logic                     v1_q, v2_q;
  logic [TAG_W-1:0]         tag1_q, tag2_q;

  always_comb begin
    for (int i = 0; i < NTAPS; i++) begin
      fm_tap[i] = fm_i[tap_lsb(i, NTAPS, DATA_W) +: DATA_W];
      wt_tap[i] = wt_i[tap_lsb(i, NTAPS, DATA_W) +: DATA_W];
      prod_c[i] = PROD_W'(fm_tap[i]) * PROD_W'(wt_tap[i]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NTAPS; i++) begin
      sum_c = sum_c + SUM_W'(prod_q[i]);
    end
  end

  // Valid bits shift every cycle; data and tags only load on valid so gaps leave them intact.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      sum_q  <= '0;
      for (int i = 0; i < NTAPS; i++) prod_q[i] <= '0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      if (valid_i) begin
        tag1_q <= tag_i;
        for (int i = 0; i < NTAPS; i++) prod_q[i] <= prod_c[i];
      end
      if (v1_q) begin
        tag2_q <= tag1_q;
        sum_q  <= sum_c;
      end
    end
  end

  assign valid_o = v2_q;
  assign tag_o   = tag2_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/conv2d_chan_acc.sv
// Channel-serial KxK convolution: accumulates IN_CH dot products plus bias per pixel,
// then applies ReLU, rounding shift and saturation.
module conv2d_chan_acc
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int KSIZE  = 3,
  parameter int IN_CH  = 4,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic [CNT_W-1:0]                 in_h_cnt,
  input  logic [CNT_W-1:0]                 in_v_cnt,
  input  logic [KSIZE*KSIZE*DATA_W-1:0]    fm_data,
  input  logic [KSIZE*KSIZE*DATA_W-1:0]    conv_weight,
  input  logic signed [DATA_W-1:0]         conv_bias,
  input  logic                             relu_en,
  input  logic [4:0]                       out_shift,
  output logic                             out_valid,
  output logic                             out_sof,
  output logic [CNT_W-1:0]                 out_h_cnt,
  output logic [CNT_W-1:0]                 out_v_cnt,
  output logic signed [OUT_W-1:0]          out_data,
  output logic                             out_sat,
  output logic                             ch_err
);

  localparam int SUM_W = sum_w(DATA_W, KSIZE);
  localparam int CH_W  = ch_w(IN_CH);
  localparam int TAG_W = 3 + 2 * CNT_W + DATA_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(IN_CH - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [ACC_W:0] ONE     = (ACC_W + 1)'(1);

  // in_valid marks one channel beat; there is no ready, so every beat is consumed and
  // every out_valid pulse must be taken by the next stage in that cycle.
  logic [CH_W-1:0]  ch_q, ch_d, beat_ch_c;
  logic             ch_err_q, ch_err_d;
  logic [TAG_W-1:0] tag_in_c;

  always_comb begin
    beat_ch_c = in_sof ? '0 : ch_q;
    ch_d      = ch_q;
    if (in_valid) ch_d = (beat_ch_c == LAST_CH) ? '0 : beat_ch_c + CH_W'(1);
    ch_err_d  = ch_err_q | (in_valid & in_sof & (ch_q != '0));
    tag_in_c  = {beat_ch_c == '0, beat_ch_c == LAST_CH, in_sof, in_h_cnt, in_v_cnt, conv_bias};
  end

  logic                     s2_valid;
  logic [TAG_W-1:0]         s2_tag;
  logic signed [SUM_W-1:0]  s2_sum;
  logic                     s2_first, s2_last, s2_sof;
  logic [CNT_W-1:0]         s2_h, s2_v;
  logic signed [DATA_W-1:0] s2_bias;

  conv_dot_kxk #(
    .DATA_W (DATA_W),
    .KSIZE  (KSIZE),
    .TAG_W  (TAG_W)
  ) u_dot (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (in_valid),
    .tag_i   (tag_in_c),
    .fm_i    (fm_data),
    .wt_i    (conv_weight),
    .valid_o (s2_valid),
    .tag_o   (s2_tag),
    .sum_o   (s2_sum)
  );

  assign s2_first = s2_tag[TAG_W-1];
  assign s2_last  = s2_tag[TAG_W-2];
  assign s2_sof   = s2_tag[TAG_W-3];
  assign s2_h     = s2_tag[DATA_W+CNT_W +: CNT_W];
  assign s2_v     = s2_tag[DATA_W +: CNT_W];
  assign s2_bias  = s2_tag[DATA_W-1:0];

  logic signed [ACC_W-1:0] acc_q;
  logic                    done_q, pix_sof_q;
  logic [CNT_W-1:0]        pix_h_q, pix_v_q;

  // A channel-0 beat restarts the accumulator, which also drops any abandoned partial pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q      <= '0;
      ch_err_q  <= 1'b0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      pix_sof_q <= 1'b0;
      pix_h_q   <= '0;
      pix_v_q   <= '0;
    end else begin
      ch_q     <= ch_d;
      ch_err_q <= ch_err_d;
      done_q   <= s2_valid & s2_last;
      if (s2_valid) begin
        if (s2_first) begin
          acc_q     <= ACC_W'(s2_sum) + ACC_W'(s2_bias);
          pix_sof_q <= s2_sof;
          pix_h_q   <= s2_h;
          pix_v_q   <= s2_v;
        end else begin
          acc_q <= acc_q + ACC_W'(s2_sum);
        end
      end
    end
  end

  logic signed [ACC_W:0]     r_c, rnd_c;
  logic signed [OUT_W-1:0]   data_c;
  logic                      sat_c;

  always_comb begin
    r_c   = (relu_en && acc_q < 0) ? '0 : (ACC_W + 1)'(acc_q);
    rnd_c = '0;
    if (out_shift != 5'd0) begin
      rnd_c = ONE <<< (out_shift - 5'd1);
      r_c   = (r_c + rnd_c) >>> out_shift;
    end
    sat_c  = 1'b0;
    data_c = r_c[OUT_W-1:0];
    if (r_c > SAT_MAX) begin
      sat_c  = 1'b1;
      data_c = SAT_MAX[OUT_W-1:0];
    end else if (r_c < SAT_MIN) begin
      sat_c  = 1'b1;
      data_c = SAT_MIN[OUT_W-1:0];
    end
  end

  logic                    out_valid_q, out_sof_q, out_sat_q;
  logic [CNT_W-1:0]        out_h_q, out_v_q;
  logic signed [OUT_W-1:0] out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_sat_q   <= 1'b0;
      out_h_q     <= '0;
      out_v_q     <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= done_q;
      out_sof_q   <= done_q & pix_sof_q;
      if (done_q) begin
        out_sat_q  <= sat_c;
        out_data_q <= data_c;
        out_h_q    <= pix_h_q;
        out_v_q    <= pix_v_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_sat   = out_sat_q;
  assign out_h_cnt = out_h_q;
  assign out_v_cnt = out_v_q;
  assign out_data  = out_data_q;
  assign ch_err    = ch_err_q;

endmodule

// File: tb/tb_conv2d_chan_acc.sv
// Directed bench for conv2d_chan_acc with KSIZE=3, IN_CH=2, 16-bit data and output.
module tb_conv2d_chan_acc;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int NT = K * K;
  localparam int IC = 2;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int CW = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_sof, relu_en;
  logic [CW-1:0]        in_h_cnt, in_v_cnt;
  logic [NT*DW-1:0]     fm_data, conv_weight;
  logic signed [DW-1:0] conv_bias;
  logic [4:0]           out_shift;
  logic                 out_valid, out_sof, out_sat, ch_err;
  logic [CW-1:0]        out_h_cnt, out_v_cnt;
  logic signed [OW-1:0] out_data;

  conv2d_chan_acc #(
    .DATA_W (DW), .KSIZE (K), .IN_CH (IC), .ACC_W (AW), .OUT_W (OW), .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_h_cnt    (in_h_cnt),
    .in_v_cnt    (in_v_cnt),
    .fm_data     (fm_data),
    .conv_weight (conv_weight),
    .conv_bias   (conv_bias),
    .relu_en     (relu_en),
    .out_shift   (out_shift),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .out_h_cnt   (out_h_cnt),
    .out_v_cnt   (out_v_cnt),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .ch_err      (ch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int cyc = 0;
  int prev_stamp = 0;
  int last_stamp = 0;
  logic signed [OW-1:0] last_data = '0;
  logic [CW-1:0]        last_h = '0;

  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      out_cnt++;
      prev_stamp = last_stamp;
      last_stamp = cyc;
      last_data  = out_data;
      last_h     = out_h_cnt;
    end
  end

  function automatic logic [NT*DW-1:0] fill(input logic [DW-1:0] v);
    logic [NT*DW-1:0] r;
    for (int i = 0; i < NT; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NT*DW-1:0] tap0_only(input logic [DW-1:0] v);
    logic [NT*DW-1:0] r;
    r = '0;
    r[(NT-1)*DW +: DW] = v;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic sof, input logic [CW-1:0] h, input logic [CW-1:0] v,
                           input logic [NT*DW-1:0] fm, input logic [NT*DW-1:0] w,
                           input logic [DW-1:0] b);
    in_valid    = 1'b1;
    in_sof      = sof;
    in_h_cnt    = h;
    in_v_cnt    = v;
    fm_data     = fm;
    conv_weight = w;
    conv_bias   = b;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_sof      = 1'b0;
    fm_data     = fill(16'hA5A5);
    conv_weight = fill(16'h5A5A);
  endtask

  // Counts edges after the sampling edge of the last beat until out_valid shows.
  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic pixel(input string tag, input logic sof, input logic [CW-1:0] h,
                       input logic [CW-1:0] v, input logic [NT*DW-1:0] fm0,
                       input logic [NT*DW-1:0] fm1, input logic [NT*DW-1:0] w,
                       input logic [DW-1:0] b, input int gap, input int exp_d,
                       input logic exp_s);
    int lat;
    send_beat(sof, h, v, fm0, w, b);
    if (gap > 0) idle(gap);
    send_beat(1'b0, 7'd127, 7'd127, fm1, w, 16'h7777);
    wait_pulse(lat);
    // Pipeline S1..S4: out_valid appears after the third edge following the sampling edge.
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_sat"}, out_sat, exp_s);
    check({tag, "_h"}, out_h_cnt, h);
    check({tag, "_v"}, out_v_cnt, v);
    check({tag, "_sof"}, out_sof, sof);
    idle(1);
    check({tag, "_pulse_end"}, out_valid, 1'b0);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_h_cnt = '0; in_v_cnt = '0;
    fm_data = '0; conv_weight = '0; conv_bias = '0; relu_en = 1'b0; out_shift = 5'd0;
    idle(3);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);
    check("rst_err", ch_err, 0);
    check("rst_h", out_h_cnt, 0);
    check("rst_sof", out_sof, 0);
    rst = 1'b0;
    idle(2);

    // 2*9 per channel, two channels, plus bias 5.
    pixel("basic", 1'b1, 7'd5, 7'd7, fill(16'd2), fill(16'd2), fill(16'd1), 16'd5, 0, 41, 1'b0);

    pixel("neg", 1'b0, 7'd1, 7'd2, fill(16'd3), fill(16'd3), fill(16'hFFFF), 16'd0, 0, -54, 1'b0);
    relu_en = 1'b1;
    pixel("relu", 1'b0, 7'd2, 7'd2, fill(16'd3), fill(16'd3), fill(16'hFFFF), 16'd0, 0, 0, 1'b0);
    relu_en = 1'b0;

    out_shift = 5'd2;
    pixel("rnd_pos", 1'b0, 7'd3, 7'd2, fill(16'd3), fill(16'd3), tap0_only(16'd1), 16'd0, 0, 2, 1'b0);
    pixel("rnd_neg", 1'b0, 7'd4, 7'd2, fill(16'hFFFD), fill(16'hFFFD), tap0_only(16'd1), 16'd0, 0,
          -1, 1'b0);
    out_shift = 5'd0;

    pixel("sat_pos", 1'b0, 7'd5, 7'd2, fill(16'h7FFF), fill(16'h7FFF), fill(16'h7FFF), 16'd0, 0,
          32767, 1'b1);
    pixel("sat_neg", 1'b0, 7'd6, 7'd2, fill(16'h7FFF), fill(16'h7FFF), fill(16'h8000), 16'd0, 0,
          -32768, 1'b1);

    // A second in_sof on what would be channel 1 abandons the first pixel.
    check("err_clean", ch_err, 0);
    c0 = out_cnt;
    send_beat(1'b1, 7'd1, 7'd1, fill(16'd9), fill(16'd1), 16'd0);
    send_beat(1'b1, 7'd2, 7'd3, fill(16'd1), fill(16'd1), 16'd0);
    send_beat(1'b0, 7'd9, 7'd9, fill(16'd1), fill(16'd1), 16'd0);
    idle(8);
    check("misalign_err", ch_err, 1);
    check("misalign_count", out_cnt - c0, 1);
    check("misalign_data", last_data, 18);
    check("misalign_h", last_h, 2);

    c0 = out_cnt;
    send_beat(1'b0, 7'd10, 7'd0, fill(16'd1), fill(16'd1), 16'd0);
    send_beat(1'b0, 7'd0, 7'd0, fill(16'd1), fill(16'd1), 16'd0);
    send_beat(1'b0, 7'd11, 7'd0, fill(16'd2), fill(16'd1), 16'd5);
    send_beat(1'b0, 7'd0, 7'd0, fill(16'd2), fill(16'd1), 16'd0);
    idle(8);
    check("b2b_count", out_cnt - c0, 2);
    check("b2b_spacing", last_stamp - prev_stamp, IC);
    check("b2b_data", last_data, 41);
    check("b2b_h", last_h, 11);

    for (int it = 0; it < 3; it++) begin
      idle($urandom_range(0, 3));
      pixel("gap", 1'b0, 7'd20, 7'd4, fill(16'd2), fill(16'd2), fill(16'd1), 16'd5,
            $urandom_range(0, 3), 41, 1'b0);
    end

    send_beat(1'b1, 7'd4, 7'd4, fill(16'd2), fill(16'd1), 16'd5);
    rst = 1'b1;
    #1;
    check("midrst_data", out_data, 0);
    check("midrst_err", ch_err, 0);
    check("midrst_h", out_h_cnt, 0);
    check("midrst_valid", out_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    c0 = out_cnt;
    idle(8);
    check("midrst_no_out", out_cnt - c0, 0);
    pixel("post_rst", 1'b1, 7'd8, 7'd9, fill(16'd2), fill(16'd2), fill(16'd1), 16'd5, 0, 41, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
